joust2_rom_loader: RTL and testbench

//  Sits between the HPS download stream (ioctl index 0) and the williams2 core's ROM/RAM write ports.

---
 rtl/joust2_rom_loader_if.sv | 32 +++
 rtl/joust2_rom_loader.sv | 140 ++++++++++++++
 tb/tb_joust2_rom_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/joust2_rom_loader_if.sv
// rtl/joust2_rom_loader_if.sv - download stream in, ROM write port and load status out
// Signals:
//   dn_download/dn_wr/dn_addr/dn_data : HPS byte stream (master drives)
//   rom_we/rom_addr/rom_data          : region write port (loader drives)
//   rom_ready/core_reset_n/load_error : load status (loader drives)
//   checksum/byte_count               : running totals of accepted bytes (loader drives)
interface joust2_rom_loader_if;
    logic        dn_download;
    logic        dn_wr;
    logic [18:0] dn_addr;
    logic [7:0]  dn_data;
    logic [3:0]  rom_we;
    logic [18:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ready;
    logic        core_reset_n;
    logic        load_error;
    logic [15:0] checksum;
    logic [18:0] byte_count;

    modport slave (
        input  dn_download, dn_wr, dn_addr, dn_data,
        output rom_we, rom_addr, rom_data, rom_ready, core_reset_n,
               load_error, checksum, byte_count
    );

    modport master (
        output dn_download, dn_wr, dn_addr, dn_data,
        input  rom_we, rom_addr, rom_data, rom_ready, core_reset_n,
               load_error, checksum, byte_count
    );
endinterface

// File: rtl/joust2_rom_loader.sv
// rtl/joust2_rom_loader.sv - splits the HPS ROM download into four regions and gates core reset
// Ports:
//   clk_sys : system clock
//   reset_n : asynchronous active-low reset
//   bus     : joust2_rom_loader_if.slave (download stream in, ROM writes and status out)
module joust2_rom_loader #(
    parameter logic [18:0] MAIN_SIZE = 19'h48000,
    parameter logic [18:0] SND_SIZE  = 19'h10000,
    parameter logic [18:0] GFX_SIZE  = 19'h0C000,
    parameter logic [18:0] CVSD_SIZE = 19'h18000
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    joust2_rom_loader_if.slave   bus
);
    localparam logic [18:0] SND_BASE  = MAIN_SIZE;
    localparam logic [18:0] GFX_BASE  = SND_BASE + SND_SIZE;
    localparam logic [18:0] CVSD_BASE = GFX_BASE + GFX_SIZE;
    // 20 bits so an image of exactly 2^19 bytes is still representable
    localparam logic [19:0] TOTAL     = {1'b0, CVSD_BASE} + {1'b0, CVSD_SIZE};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERROR} state_t;

    state_t      state_q, state_d;
    logic        dl_q;
    logic [19:0] count_q, count_d;
    logic [15:0] sum_q, sum_d;
    logic [3:0]  we_q, we_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    logic        rise, fall, in_seq, full;
    logic        accept, clear, ready, error;
    logic [3:0]  sel;
    logic [18:0] offset;

    assign rise   = bus.dn_download & ~dl_q;
    assign fall   = ~bus.dn_download & dl_q;
    assign in_seq = ({1'b0, bus.dn_addr} == count_q);
    assign full   = (count_q == TOTAL);

    // Region select and region-relative address from the parameter boundaries
    always_comb begin
        sel    = 4'b1000;
        offset = bus.dn_addr - CVSD_BASE;
        if (bus.dn_addr < SND_BASE) begin
            sel    = 4'b0001;
            offset = bus.dn_addr;
        end else if (bus.dn_addr < GFX_BASE) begin
            sel    = 4'b0010;
            offset = bus.dn_addr - SND_BASE;
        end else if (bus.dn_addr < CVSD_BASE) begin
            sel    = 4'b0100;
            offset = bus.dn_addr - GFX_BASE;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q    <= bus.dn_download;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (rise) state_d = S_LOAD;
            S_LOAD: begin
                // A bad strobe wins over a coincident falling edge
                if (rise)                                  state_d = S_LOAD;
                else if (bus.dn_wr && (!in_seq || full))   state_d = S_ERROR;
                else if (fall)                             state_d = S_CHECK;
            end
            S_CHECK: state_d = full ? S_DONE : S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        clear  = 1'b0;
        ready  = (state_q == S_DONE);
        error  = (state_q == S_ERROR);
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: clear = rise;
            S_LOAD: begin
                clear  = rise;
                accept = ~rise & bus.dn_wr & in_seq & ~full;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        sum_d   = sum_q;
        we_d    = 4'b0000;
        addr_d  = addr_q;
        data_d  = data_q;
        if (clear) begin
            count_d = 20'd0;
            sum_d   = 16'd0;
        end else if (accept) begin
            count_d = count_q + 20'd1;
            sum_d   = sum_q + {8'h00, bus.dn_data};
            we_d    = sel;
            addr_d  = offset;
            data_d  = bus.dn_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 20'd0;
            sum_q   <= 16'd0;
            we_q    <= 4'b0000;
            addr_q  <= 19'd0;
            data_q  <= 8'd0;
        end else begin
            count_q <= count_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.rom_we       = we_q;
    assign bus.rom_addr     = addr_q;
    assign bus.rom_data     = data_q;
    assign bus.rom_ready    = ready;
    assign bus.core_reset_n = ready;
    assign bus.load_error   = error;
    assign bus.checksum     = sum_q;
    assign bus.byte_count   = count_q[18:0];
endmodule

// File: tb/tb_joust2_rom_loader.sv
// tb/tb_joust2_rom_loader.sv - self-checking bench for joust2_rom_loader with scaled region sizes
module tb_joust2_rom_loader;
    localparam int MAIN = 'h480, SND = 'h100, GFX = 'hC0, CVSD = 'h180;
    localparam int TOT  = MAIN + SND + GFX + CVSD;   // 0x7C0

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    joust2_rom_loader_if bus();

    joust2_rom_loader #(
        .MAIN_SIZE(19'h480), .SND_SIZE(19'h100), .GFX_SIZE(19'h0C0), .CVSD_SIZE(19'h180)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          addr;
        logic [3:0]  we;
        logic [18:0] raddr;
    } vec_t;
    vec_t tbl[8];

    int tests = 0;
    int fails = 0;
    int wr_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_dl;
        bus.dn_download = 1'b1;
        bus.dn_wr       = 1'b0;
        tick();
    endtask

    // Streams bytes back-to-back, data = addr[7:0]; each strobe's write is visible right after its edge
    task automatic load_bytes(input int first, input int n, input bit use_tbl);
        logic [3:0]  ew;
        logic [18:0] ea;
        for (int a = first; a < first + n; a++) begin
            bus.dn_wr   = 1'b1;
            bus.dn_addr = a[18:0];
            bus.dn_data = a[7:0];
            tick();
            if (a < MAIN)                  begin ew = 4'b0001; ea = a[18:0]; end
            else if (a < MAIN + SND)       begin ew = 4'b0010; ea = 19'(a - MAIN); end
            else if (a < MAIN + SND + GFX) begin ew = 4'b0100; ea = 19'(a - MAIN - SND); end
            else                           begin ew = 4'b1000; ea = 19'(a - MAIN - SND - GFX); end
            if (bus.rom_we !== ew || bus.rom_addr !== ea || bus.rom_data !== a[7:0]) wr_bad++;
            if (use_tbl) begin
                for (int i = 0; i < 8; i++) begin
                    if (tbl[i].addr == a) begin
                        check($sformatf("tbl%0d_we", i), {28'd0, bus.rom_we}, {28'd0, tbl[i].we});
                        check($sformatf("tbl%0d_addr", i), {13'd0, bus.rom_addr}, {13'd0, tbl[i].raddr});
                        check($sformatf("tbl%0d_data", i), {24'd0, bus.rom_data}, a & 'hFF);
                    end
                end
            end
        end
        bus.dn_wr = 1'b0;
    endtask

    initial begin
        tbl[0] = '{'h000, 4'b0001, 19'h000};
        tbl[1] = '{'h47F, 4'b0001, 19'h47F};
        tbl[2] = '{'h480, 4'b0010, 19'h000};
        tbl[3] = '{'h57F, 4'b0010, 19'h0FF};
        tbl[4] = '{'h580, 4'b0100, 19'h000};
        tbl[5] = '{'h63F, 4'b0100, 19'h0BF};
        tbl[6] = '{'h640, 4'b1000, 19'h000};
        tbl[7] = '{'h7BF, 4'b1000, 19'h17F};

        bus.dn_download = 1'b0;
        bus.dn_wr       = 1'b0;
        bus.dn_addr     = '0;
        bus.dn_data     = '0;
        tick(); tick();
        check("rst_we", {28'd0, bus.rom_we}, 0);
        check("rst_ready", {31'd0, bus.rom_ready}, 0);
        check("rst_core", {31'd0, bus.core_reset_n}, 0);
        check("rst_err", {31'd0, bus.load_error}, 0);
        check("rst_sum", {16'd0, bus.checksum}, 0);
        check("rst_cnt", {13'd0, bus.byte_count}, 0);
        reset_n = 1'b1;
        tick();

        // strobe outside LOAD is ignored
        bus.dn_wr = 1'b1; bus.dn_addr = '0; bus.dn_data = 8'h5A;
        tick();
        bus.dn_wr = 1'b0;
        check("idle_we", {28'd0, bus.rom_we}, 0);
        check("idle_cnt", {13'd0, bus.byte_count}, 0);

        // full image
        wr_bad = 0;
        start_dl();
        load_bytes(0, TOT, 1'b1);
        check("full_writes", wr_bad, 0);
        bus.dn_download = 1'b0;
        tick();
        check("full_we_idle", {28'd0, bus.rom_we}, 0);
        check("full_addr_hold", {13'd0, bus.rom_addr}, 'h17F);
        check("check_ready", {31'd0, bus.rom_ready}, 0);
        tick();
        check("done_ready", {31'd0, bus.rom_ready}, 1);
        check("done_core", {31'd0, bus.core_reset_n}, 1);
        check("done_err", {31'd0, bus.load_error}, 0);
        check("done_cnt", {13'd0, bus.byte_count}, 'h7C0);
        check("done_sum", {16'd0, bus.checksum}, 'hC420);

        // restart from DONE
        start_dl();
        check("restart_ready", {31'd0, bus.rom_ready}, 0);
        check("restart_cnt", {13'd0, bus.byte_count}, 0);
        check("restart_sum", {16'd0, bus.checksum}, 0);

        // short image
        load_bytes(0, 'h100, 1'b0);
        bus.dn_download = 1'b0;
        tick();
        check("short_check_err", {31'd0, bus.load_error}, 0);
        tick();
        check("short_err", {31'd0, bus.load_error}, 1);
        check("short_ready", {31'd0, bus.rom_ready}, 0);

        // address skip
        start_dl();
        check("skip_err_clr", {31'd0, bus.load_error}, 0);
        load_bytes(0, 4, 1'b0);
        bus.dn_wr = 1'b1; bus.dn_addr = 19'd5; bus.dn_data = 8'h05;
        tick();
        check("skip_we", {28'd0, bus.rom_we}, 0);
        check("skip_err", {31'd0, bus.load_error}, 1);
        bus.dn_addr = 19'd4; bus.dn_data = 8'h04;
        tick();
        bus.dn_wr = 1'b0;
        check("skip_later_we", {28'd0, bus.rom_we}, 0);
        check("skip_cnt", {13'd0, bus.byte_count}, 4);
        bus.dn_download = 1'b0;
        tick();

        // last byte coincident with download falling
        wr_bad = 0;
        start_dl();
        load_bytes(0, TOT - 1, 1'b0);
        bus.dn_download = 1'b0;
        bus.dn_wr = 1'b1; bus.dn_addr = 19'h7BF; bus.dn_data = 8'hBF;
        tick();
        bus.dn_wr = 1'b0;
        check("coinc_writes", wr_bad, 0);
        check("coinc_we", {28'd0, bus.rom_we}, 'b1000);
        check("coinc_addr", {13'd0, bus.rom_addr}, 'h17F);
        check("coinc_data", {24'd0, bus.rom_data}, 'hBF);
        tick();
        check("coinc_ready", {31'd0, bus.rom_ready}, 1);

        // overflow strobe after a complete image
        start_dl();
        load_bytes(0, TOT, 1'b0);
        bus.dn_wr = 1'b1; bus.dn_addr = 19'h7C0; bus.dn_data = 8'hC0;
        tick();
        bus.dn_wr = 1'b0;
        check("ovf_we", {28'd0, bus.rom_we}, 0);
        check("ovf_err", {31'd0, bus.load_error}, 1);
        check("ovf_cnt", {13'd0, bus.byte_count}, 'h7C0);
        bus.dn_download = 1'b0;
        tick();

        // asynchronous reset mid-load
        start_dl();
        load_bytes(0, 'h101, 1'b0);
        check("pre_rst_we", {28'd0, bus.rom_we}, 'b0001);
        reset_n = 1'b0;
        #1;
        check("async_we", {28'd0, bus.rom_we}, 0);
        check("async_cnt", {13'd0, bus.byte_count}, 0);
        bus.dn_download = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, bus.rom_ready}, 0);
        check("post_rst_err", {31'd0, bus.load_error}, 0);
        wr_bad = 0;
        start_dl();
        load_bytes(0, TOT, 1'b0);
        bus.dn_download = 1'b0;
        tick(); tick();
        check("reload_writes", wr_bad, 0);
        check("reload_ready", {31'd0, bus.rom_ready}, 1);
        check("reload_sum", {16'd0, bus.checksum}, 'hC420);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
